regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised, multi-read-port register file with a per-register scoreboard and a post-reset clear sequencer.
- Successor to the single-port decode-stage register array: generalised in data width, depth and read-port count.
- Adds write-to-read forwarding, busy tracking for in-flight producers (e.g. loads), and a hardware zeroing sequence after reset.
- Sits in the ID stage; the hazard unit consumes Rbusy to generate stalls.

Parameters:
- DATA_W, 32, register width in bits.
- NREG, 32, number of architectural registers (power of two, >= 2).
- ADDR_W, $clog2(NREG), register address width (derived; not overridden).
- NRD, 2, number of independent read ports.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset, synchronous, active-low.
- Raddr  input  NRD*ADDR_W  read addresses; port i is bits [i*ADDR_W +: ADDR_W].
- Rdata  output  NRD*DATA_W  read data; port i is bits [i*DATA_W +: DATA_W].
- Rbusy  output  NRD  port i addresses a register reserved by an in-flight producer.
- WE  input  1  write enable.
- Waddr  input  ADDR_W  write address.
- Wdata  input  DATA_W  write data.
- Rsv  input  1  reserve request: mark Rsv_addr busy.
- Rsv_addr  input  ADDR_W  register to reserve.
- Ready  output  1  clear sequence done; the block accepts writes and reservations.

Behaviour:
- Register 0 is hardwired to zero:
  - writes to it are discarded;
  - reservations of it are discarded;
  - reads of it return 0 with Rbusy=0.
- State machine, two states: CLEAR and RUN. All state is registered.
- Reset:
  - Any posedge with RST=0 forces state=CLEAR, clear counter cnt=0 and all busy bits=0.
  - Ready is registered and reads 0 from the first edge after RST is sampled low.
  - Reset taken mid-CLEAR or mid-RUN restarts the sequence from cnt=0.
- CLEAR:
  - Each posedge with RST=1 writes Reg[cnt]<=0 and increments cnt.
  - When cnt==NREG-1, that edge also sets state<=RUN and Ready<=1.
  - Ready therefore rises exactly NREG edges after RST is first sampled high.
  - WE and Rsv are ignored; Rdata is forced to 0 and Rbusy to 0.
- Read path (RUN), combinational, zero latency:
  - Rdata_i = Reg[Raddr_i].
  - Rbusy_i = busy[Raddr_i], overridden as listed below.
- Write (RUN): at a posedge with WE=1 and Waddr!=0:
  - Reg[Waddr]<=Wdata;
  - busy[Waddr]<=0.
- Reserve (RUN): at a posedge with Rsv=1 and Rsv_addr!=0, busy[Rsv_addr]<=1.
- Simultaneous write and reserve:
  - Same register: the reserve wins and busy ends at 1; the data write still occurs.
  - Different registers: both take effect.
- Rbusy override: Rbusy_i=0 when WE=1 and Waddr==Raddr_i (the producer completes this cycle).
  - This override applies regardless of the optional feature.
- Duplicate read addresses across ports are legal; the ports return identical data.
- No overflow or underflow exists: busy is a single bit. Reserving an already-busy register leaves it busy.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: the write port is forwarded combinationally.
  - Condition: WE=1, Waddr!=0, Waddr==Raddr_i and state RUN.
  - Result: Rdata_i=Wdata in the same cycle.
- Undefined: Rdata_i returns the stored value until the edge.
  - The pipeline must then write back on the first half or stall one cycle.
  - Rbusy behaviour is unchanged.

Decomposition:
- Shared constants go in common_param.vh:
  - REGFILE_SIZE (default for NREG);
  - ZERO_REG=0;
  - LINK_REG=REGFILE_SIZE-1;
  - state encodings ST_CLEAR=1'b0, ST_RUN=1'b1.
- One natural sub-module: regfile_scoreboard.
  - Contents: the NREG-bit busy vector, reserve/clear logic and the per-port Rbusy mux.
  - Instantiated once, sharing CLK/RST.
- The read ports are a generate loop over NRD inside regfile_sb.

Test Plan:
1. Reset and clear:
   - Stimulus: preload Reg[5]=32'hDEAD via writes, pulse RST low 1 cycle, release.
   - Required: Ready=0 for exactly 32 edges then 1; Raddr0=5 returns 0; writes issued during CLEAR leave registers 0.
2. Write then read:
   - Stimulus: WE=1, Waddr=7, Wdata=32'h1234_5678.
   - Required: next cycle Raddr0=Raddr1=7 both return 32'h12345678.
   - Stimulus: WE=1, Waddr=0, Wdata=32'hFFFF_FFFF.
   - Required: Raddr0=0 returns 0.
3. Bypass:
   - Stimulus: WE=1, Waddr=9, Wdata=32'hA5A5, Raddr0=9 in the same cycle.
   - Required: with REGFILE_BYPASS_EN, Rdata0=32'hA5A5 that cycle; without it, the old value that cycle and 32'hA5A5 the next.
4. Scoreboard:
   - Stimulus: Rsv=1, Rsv_addr=3; next cycle Raddr1=3.
   - Required: Rbusy[1]=1.
   - Stimulus: WE=1, Waddr=3.
   - Required: Rbusy[1]=0 in that cycle and after.
   - Stimulus: Rsv to register 0.
   - Required: Rbusy stays 0.
5. Collision:
   - Stimulus: Rsv=1, Rsv_addr=4 and WE=1, Waddr=4, Wdata=32'h77 on the same edge.
   - Required: next cycle Reg[4]=32'h77 and Rbusy for address 4 = 1.
6. Reset mid-run:
   - Stimulus: busy[3]=1 and Reg[3]=32'h55; assert RST low 1 cycle.
   - Required: Ready=0, Rbusy=0; after 32 edges Ready=1 and Reg[3]=0.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg: constants and types shared by the ID-stage register file
// and its scoreboard.
//   REGFILE_SIZE : default architectural register count
//   ZERO_REG     : index of the hardwired-zero register
//   LINK_REG     : index of the link register (last register)
//   state_t      : sequencer states, ST_CLEAR (zeroing after reset) and ST_RUN
package regfile_sb_pkg;

  localparam int REGFILE_SIZE = 32;
  localparam int ZERO_REG     = 0;
  localparam int LINK_REG     = REGFILE_SIZE - 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// regfile_scoreboard: one busy bit per register, set by a reservation from an
// in-flight producer and cleared by that producer's write-back.
// Ports:
//   CLK, RST   clock and synchronous active-low reset (clears all busy bits)
//   run        high when the register file is in its RUN state
//   WE, Waddr  write port; a write releases the target register
//   Rsv,
//   Rsv_addr   reservation request; marks the target register busy
//   Raddr      packed read addresses, NRD ports of ADDR_W bits
//   Rbusy      per-port busy flag for the hazard unit
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int NREG   = REGFILE_SIZE,
  parameter int ADDR_W = $clog2(NREG),
  parameter int NRD    = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  run,
  input  logic                  WE,
  input  logic [ADDR_W-1:0]     Waddr,
  input  logic                  Rsv,
  input  logic [ADDR_W-1:0]     Rsv_addr,
  input  logic [NRD*ADDR_W-1:0] Raddr,
  output logic [NRD-1:0]        Rbusy
);

  logic [NREG-1:0] busy;

  // The reserve update is placed after the write release so that, when both
  // target the same register on one edge, the reservation is what remains.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      busy <= '0;
    end else if (run) begin
      if (WE && Waddr != ADDR_W'(ZERO_REG))
        busy[Waddr] <= 1'b0;
      if (Rsv && Rsv_addr != ADDR_W'(ZERO_REG))
        busy[Rsv_addr] <= 1'b1;
    end
  end

  // A producer writing back this cycle is no longer a hazard for its readers.
  for (genvar g = 0; g < NRD; g++) begin : g_busy
    logic [ADDR_W-1:0] ra;
    assign ra = Raddr[g*ADDR_W +: ADDR_W];
    assign Rbusy[g] = run && (ra != ADDR_W'(ZERO_REG)) && busy[ra] &&
                      !(WE && (Waddr == ra));
  end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised multi-read-port register file with a per-register
// scoreboard and a post-reset sequencer that zeroes every register.
// Optional feature macro: REGFILE_BYPASS_EN forwards Wdata to a read port that
// addresses the register being written in the same cycle.
// Ports:
//   CLK, RST   clock and synchronous active-low reset
//   Raddr      NRD packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   Rdata      NRD packed read data, port i at [i*DATA_W +: DATA_W]
//   Rbusy      per-port: addressed register is reserved by a producer
//   WE, Waddr,
//   Wdata      write port
//   Rsv,
//   Rsv_addr   reservation request
//   Ready      clear sequence finished, writes and reservations accepted
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int NREG   = REGFILE_SIZE,
  parameter  int NRD    = 2,
  localparam int ADDR_W = $clog2(NREG)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NRD*ADDR_W-1:0] Raddr,
  output logic [NRD*DATA_W-1:0] Rdata,
  output logic [NRD-1:0]        Rbusy,
  input  logic                  WE,
  input  logic [ADDR_W-1:0]     Waddr,
  input  logic [DATA_W-1:0]     Wdata,
  input  logic                  Rsv,
  input  logic [ADDR_W-1:0]     Rsv_addr,
  output logic                  Ready
);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              run;
  logic [DATA_W-1:0] regs [NREG];

  assign run   = (state == ST_RUN);
  assign Ready = run;

  // Sequencer and storage. After reset one register is zeroed per edge; the
  // edge that zeroes the last register also moves the block into RUN.
  // The storage itself has no reset: the clear sequence takes care of it.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          regs[cnt] <= '0;
          cnt       <= cnt + 1'b1;
          if (cnt == ADDR_W'(NREG - 1))
            state <= ST_RUN;
        end
        ST_RUN: begin
          if (WE && Waddr != ADDR_W'(ZERO_REG))
            regs[Waddr] <= Wdata;
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  // Combinational read ports; register 0 and the whole CLEAR phase read as 0.
  for (genvar g = 0; g < NRD; g++) begin : g_read
    logic [ADDR_W-1:0] ra;
    assign ra = Raddr[g*ADDR_W +: ADDR_W];
    always_comb begin
      Rdata[g*DATA_W +: DATA_W] = regs[ra];
      if (!run || ra == ADDR_W'(ZERO_REG))
        Rdata[g*DATA_W +: DATA_W] = '0;
`ifdef REGFILE_BYPASS_EN
      else if (WE && Waddr == ra)
        Rdata[g*DATA_W +: DATA_W] = Wdata;
`endif
    end
  end

  regfile_scoreboard #(
    .NREG   (NREG),
    .ADDR_W (ADDR_W),
    .NRD    (NRD)
  ) u_scoreboard (
    .CLK      (CLK),
    .RST      (RST),
    .run      (run),
    .WE       (WE),
    .Waddr    (Waddr),
    .Rsv      (Rsv),
    .Rsv_addr (Rsv_addr),
    .Raddr    (Raddr),
    .Rbusy    (Rbusy)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and randomised checks of regfile_sb against a
// behavioural model of the register file held as plain arrays.
module tb_regfile_sb;

  localparam int DATA_W = 32;
  localparam int NREG   = 32;
  localparam int NRD    = 2;
  localparam int AW     = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                  CLK;
  logic                  RST;
  logic [NRD*AW-1:0]     Raddr;
  logic [NRD*DATA_W-1:0] Rdata;
  logic [NRD-1:0]        Rbusy;
  logic                  WE;
  logic [AW-1:0]         Waddr;
  logic [DATA_W-1:0]     Wdata;
  logic                  Rsv;
  logic [AW-1:0]         Rsv_addr;
  logic                  Ready;

  int n_vec  = 0;
  int n_miss = 0;

  regfile_sb #(.DATA_W(DATA_W), .NREG(NREG), .NRD(NRD)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .Raddr    (Raddr),
    .Rdata    (Rdata),
    .Rbusy    (Rbusy),
    .WE       (WE),
    .Waddr    (Waddr),
    .Wdata    (Wdata),
    .Rsv      (Rsv),
    .Rsv_addr (Rsv_addr),
    .Ready    (Ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: register contents, busy flags, and how many clearing
  // edges have passed since the last reset.
  logic [DATA_W-1:0] m_reg [NREG];
  bit                m_busy [NREG];
  bit                m_run = 1'b0;
  bit                m_started = 1'b0;
  int                m_clr_edges = 0;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: reset, then NREG clearing edges, then normal operation.
  always @(posedge CLK) begin
    if (!RST) begin
      m_started   = 1'b1;
      m_run       = 1'b0;
      m_clr_edges = 0;
      for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    end else if (!m_run) begin
      m_clr_edges++;
      if (m_clr_edges == NREG) begin
        m_run = 1'b1;
        for (int i = 0; i < NREG; i++) m_reg[i] = '0;
      end
    end else begin
      if (WE && Waddr != 0) begin
        m_reg[Waddr]  = Wdata;
        m_busy[Waddr] = 1'b0;
      end
      if (Rsv && Rsv_addr != 0) m_busy[Rsv_addr] = 1'b1;
    end
  end

  // Compare process: every cycle, mid-period, all outputs against the model.
  always @(negedge CLK) begin
    if (m_started) begin
      check_output("ready", 32'(Ready), 32'(m_run));
      for (int p = 0; p < NRD; p++) begin
        automatic logic [AW-1:0]     a = Raddr[p*AW +: AW];
        automatic logic [DATA_W-1:0] ed;
        automatic logic              eb;
        if (!m_run || a == 0) ed = '0;
        else if (BYPASS && WE && Waddr == a) ed = Wdata;
        else ed = m_reg[a];
        eb = m_run && a != 0 && m_busy[a] && !(WE && Waddr == a);
        check_output($sformatf("rdata%0d", p), Rdata[p*DATA_W +: DATA_W], ed);
        check_output($sformatf("rbusy%0d", p), 32'(Rbusy[p]), 32'(eb));
      end
    end
  end

  // Drive one cycle of inputs just after a rising edge, then settle so the
  // caller can inspect the combinational outputs for that cycle.
  task automatic apply_stimulus(input logic rst, input logic we,
                                input logic [AW-1:0] wa, input logic [DATA_W-1:0] wd,
                                input logic rsv, input logic [AW-1:0] rsa,
                                input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    @(posedge CLK);
    #1;
    RST = rst; WE = we; Waddr = wa; Wdata = wd;
    Rsv = rsv; Rsv_addr = rsa; Raddr = {ra1, ra0};
    #2;
  endtask

  // Count rising edges with RST high until Ready appears; the caller has
  // just released reset. Write/reserve inputs are dropped once Ready is seen.
  task automatic wait_ready(input string name);
    int n = 0;
    while (Ready !== 1'b1 && n < 200) begin
      @(posedge CLK);
      #1;
      n++;
    end
    WE = 1'b0; Rsv = 1'b0;
    check_output(name, 32'(n), 32'(NREG));
  endtask

  initial begin
    RST = 1'b0; WE = 1'b0; Waddr = '0; Wdata = '0;
    Rsv = 1'b0; Rsv_addr = '0; Raddr = '0;

    // Power-up reset and first clear.
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0);
    check_output("ready_after_reset", 32'(Ready), 32'd0);
    wait_ready("clear_len_first");

    // Reset wipes a preloaded value; writes and reserves during CLEAR are ignored.
    apply_stimulus(1, 1, 5, 32'hDEAD, 0, 0, 5, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 5, 0);
    check_output("preload_r5", Rdata[31:0], 32'hDEAD);
    apply_stimulus(0, 0, 0, 0, 0, 0, 5, 0);
    apply_stimulus(1, 1, 10, 32'hBEEF, 1, 10, 5, 10);
    check_output("ready_low_in_clear", 32'(Ready), 32'd0);
    wait_ready("clear_len_second");
    apply_stimulus(1, 0, 0, 0, 0, 0, 5, 10);
    check_output("r5_cleared", Rdata[31:0], 32'd0);
    check_output("r10_clear_write_ignored", Rdata[63:32], 32'd0);
    check_output("r10_clear_rsv_ignored", 32'(Rbusy[1]), 32'd0);

    // Write then read on both ports; register 0 stays zero.
    apply_stimulus(1, 1, 7, 32'h1234_5678, 0, 0, 7, 7);
    apply_stimulus(1, 1, 0, 32'hFFFF_FFFF, 0, 0, 7, 7);
    check_output("r7_port0", Rdata[31:0], 32'h1234_5678);
    check_output("r7_port1", Rdata[63:32], 32'h1234_5678);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0);
    check_output("r0_zero", Rdata[31:0], 32'd0);

    // Bypass: old value 32'h1111 is visible unless forwarding is built in.
    apply_stimulus(1, 1, 9, 32'h1111, 0, 0, 0, 0);
    apply_stimulus(1, 1, 9, 32'hA5A5, 0, 0, 9, 0);
    check_output("bypass_same_cycle", Rdata[31:0], BYPASS ? 32'hA5A5 : 32'h1111);
    apply_stimulus(1, 0, 0, 0, 0, 0, 9, 0);
    check_output("bypass_next_cycle", Rdata[31:0], 32'hA5A5);

    // Scoreboard reserve, release by write, reserve of register 0.
    apply_stimulus(1, 0, 0, 0, 1, 3, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 3);
    check_output("r3_busy", 32'(Rbusy[1]), 32'd1);
    apply_stimulus(1, 1, 3, 32'h33, 0, 0, 0, 3);
    check_output("r3_release_same_cycle", 32'(Rbusy[1]), 32'd0);
    apply_stimulus(1, 0, 0, 0, 1, 0, 0, 3);
    check_output("r3_release_after", 32'(Rbusy[1]), 32'd0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0);
    check_output("r0_rsv_ignored", 32'(Rbusy), 32'd0);

    // Collision: reserve and write of the same register on one edge.
    apply_stimulus(1, 1, 4, 32'h77, 1, 4, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0, 4, 0);
    check_output("r4_collision_data", Rdata[31:0], 32'h77);
    check_output("r4_collision_busy", 32'(Rbusy[0]), 32'd1);

    // Reset mid-run with a busy, non-zero register.
    apply_stimulus(1, 1, 3, 32'h55, 1, 3, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 3, 3);
    check_output("r3_before_reset", Rdata[31:0], 32'h55);
    apply_stimulus(1, 0, 0, 0, 0, 0, 3, 3);
    check_output("ready_mid_reset", 32'(Ready), 32'd0);
    check_output("rbusy_mid_reset", 32'(Rbusy), 32'd0);
    wait_ready("clear_len_midrun");
    apply_stimulus(1, 0, 0, 0, 0, 0, 3, 0);
    check_output("r3_after_clear", Rdata[31:0], 32'd0);
    check_output("r3_busy_after_clear", 32'(Rbusy[0]), 32'd0);

    // Randomised traffic with occasional resets; read addresses often
    // collide with the write address to exercise forwarding and release.
    for (int i = 0; i < 1500; i++) begin
      automatic logic [AW-1:0] wa  = AW'($urandom_range(0, NREG - 1));
      automatic logic [AW-1:0] r0  = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, NREG - 1));
      automatic logic [AW-1:0] r1  = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, NREG - 1));
      automatic logic [AW-1:0] rsa = ($urandom_range(0, 5) == 0) ? wa : AW'($urandom_range(0, NREG - 1));
      apply_stimulus(($urandom_range(0, 299) != 0), 1'($urandom_range(0, 1)), wa, $urandom(),
                     1'($urandom_range(0, 2) == 0), rsa, r0, r1);
    end

    @(posedge CLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
